gups_engine: RTL and testbench

Parametrised random-access read-modify-write (GUPS) traffic engine. A Galois LFSR generates pseudo-random addresses, which are masked to a configurable range. For each address the engine reads the memory word, applies an update (increment or XOR with the random value) and writes the result back to the same address. It runs a programmable number of updates per start command. It drives a single memory port with separate request-accept and read-return handshakes. It sits between the benchmark control registers and the memory controller.

---
 rtl/gups_engine.sv | 166 ++++++++++++++++
 tb/tb_gups_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gups_engine.sv
// GUPS random-access read-modify-write engine: a Galois LFSR picks masked
// addresses; each word is read, updated (increment or XOR) and written back.
module gups_engine #(
    parameter int          ADDR_W       = 64,
    parameter int          DATA_W       = 64,
    parameter int          SEED_W       = 16,
    parameter logic [63:0] POLY         = 64'hD800_0000_0000_0000,
    parameter int          WARMUP_STEPS = 4,
    parameter int          CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic [ADDR_W-1:0] range_mask,
    input  logic [CNT_W-1:0]  num_updates,
    input  logic              mode,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  update_count
);
    localparam logic [DATA_W-1:0] POLY_L = POLY[DATA_W-1:0];
    localparam int WW    = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
    localparam int WLAST = (WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0;
    localparam logic [WW-1:0] WLAST_C = WW'(WLAST);

    typedef enum logic [2:0] {IDLE, WARMUP, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]     warm_q, warm_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] lfsr_addr;
    logic [DATA_W-1:0] seed_ext;
    logic              accept;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
        return v[0] ? ((v >> 1) ^ POLY_L) : (v >> 1);
    endfunction

    if (ADDR_W > DATA_W) begin : g_addr_wide
        assign lfsr_addr = {{(ADDR_W-DATA_W){1'b0}}, lfsr_q};
    end else begin : g_addr_narrow
        assign lfsr_addr = lfsr_q[ADDR_W-1:0];
    end

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    assign seed_ext = (seed == '0) ? DATA_W'(1) : DATA_W'(seed);
    assign accept   = req_q && mem_ready;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        mask_d  = mask_q;
        num_d   = num_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                // A zero-length run parks in DONE with busy set for one cycle.
                if (state_q == DONE && busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (start) begin
                    mask_d = range_mask;
                    num_d  = num_updates;
                    mode_d = mode;
                    lfsr_d = seed_ext;
                    cnt_d  = '0;
                    warm_d = '0;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                    if (num_updates == '0)    state_d = DONE;
                    else if (WARMUP_STEPS > 0) state_d = WARMUP;
                    else                       state_d = RD_REQ;
                end
            end
            WARMUP: begin
                lfsr_d = lfsr_step(lfsr_q);
                warm_d = warm_q + WW'(1);
                if (warm_q == WLAST_C) state_d = RD_REQ;
            end
            RD_REQ: if (accept) state_d = RD_WAIT;
            RD_WAIT: begin
                if (mem_rvalid) begin
                    wdata_d = mode_q ? (mem_rdata ^ lfsr_q) : (mem_rdata + DATA_W'(1));
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (accept) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_d == num_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == RD_REQ) || (state_d == WR_REQ);
        we_d  = (state_d == WR_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            mask_q  <= '0;
            num_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            warm_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = lfsr_addr & mask_q;
    assign mem_wdata    = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign update_count = cnt_q;
endmodule

// File: tb/tb_gups_engine.sv
// Bench for gups_engine: two instances (no warmup / 4 warmup steps) against a
// transaction-level model with its own memory, plus literal expectations.
module tb_gups_engine;
    localparam int AW = 64, DW = 64, SW = 16, CW = 32;
    localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
    logic [SW-1:0] seed = '0;
    logic [AW-1:0] range_mask = '1;
    logic [CW-1:0] num_updates = '0;

    logic          mem_req_a [2], mem_we_a [2], busy_a [2], done_a [2];
    logic [AW-1:0] mem_addr_a [2];
    logic [DW-1:0] mem_wdata_a [2], mem_rdata_a [2];
    logic [CW-1:0] cnt_a [2];
    logic          mem_ready_a [2], mem_rvalid_a [2];

    int checks = 0, failures = 0;

    // memory responder configuration
    int          stall_len = 0, rd_lat = 1;
    logic [63:0] fill = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        gups_engine #(.ADDR_W(AW), .DATA_W(DW), .SEED_W(SW), .POLY(POLY),
                      .WARMUP_STEPS(g * 4), .CNT_W(CW)) u_dut (
            .clk(clk), .reset(reset), .start(start), .seed(seed),
            .range_mask(range_mask), .num_updates(num_updates), .mode(mode),
            .mem_req(mem_req_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
            .mem_wdata(mem_wdata_a[g]), .mem_ready(mem_ready_a[g]),
            .mem_rvalid(mem_rvalid_a[g]), .mem_rdata(mem_rdata_a[g]),
            .busy(busy_a[g]), .done(done_a[g]), .update_count(cnt_a[g]));
    end

    // model memory, keyed by {instance, address}
    logic [63:0] ram [logic [64:0]];
    logic [63:0] log_addr [$];
    logic [63:0] log_wd [$];
    logic        log_we [$];

    function automatic logic [63:0] nxt(input logic [63:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    function automatic logic [63:0] rdv(input int g, input logic [63:0] a);
        logic [64:0] k;
        k = {1'(g), a};
        return ram.exists(k) ? ram[k] : fill;
    endfunction

    // model state
    logic        armed = 1'b0;
    logic        erun [2], ebusy [2], edone [2], zpend [2], wrph [2], emode [2];
    logic [63:0] elf [2], emask [2], eaddr [2], ewd [2];
    logic [31:0] enum_q [2], ecnt [2];
    // responder state and values sampled at the previous negedge
    int          wait_cnt [2] = '{0, 0}, rd_cnt [2] = '{0, 0};
    logic [63:0] rd_addr [2];
    logic        l_req [2] = '{1'b0, 1'b0}, l_rdy [2] = '{1'b0, 1'b0}, l_we [2];
    logic [63:0] l_addr [2], l_wd [2];
    logic        l_rst = 1'b0, l_start = 1'b0, l_mode = 1'b0;
    logic [15:0] l_seed = '0;
    logic [63:0] l_mask = '0;
    logic [31:0] l_num = '0;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (armed && !l_rst && l_req[g] && !l_rdy[g]) begin
                checks++;
                if (mem_req_a[g] !== 1'b1 || mem_we_a[g] !== l_we[g] ||
                    mem_addr_a[g] !== l_addr[g] || mem_wdata_a[g] !== l_wd[g])
                begin
                    failures++;
                    $display("FAIL hold inst=%0d req=%b we=%b addr=%h wd=%h required req=1 we=%b addr=%h wd=%h",
                             g, mem_req_a[g], mem_we_a[g], mem_addr_a[g], mem_wdata_a[g],
                             l_we[g], l_addr[g], l_wd[g]);
                end
            end
            if (l_rst) begin
                erun[g] = 0; ebusy[g] = 0; edone[g] = 0; zpend[g] = 0; wrph[g] = 0;
                ecnt[g] = '0;
            end else if (armed) begin
                if (l_req[g] && l_rdy[g]) begin
                    checks++;
                    if (!erun[g]) begin
                        failures++;
                        $display("FAIL spurious_access inst=%0d addr=%h required no access", g, l_addr[g]);
                    end else if (!wrph[g]) begin
                        if (l_we[g] !== 1'b0 || l_addr[g] !== eaddr[g]) begin
                            failures++;
                            $display("FAIL rd_req inst=%0d we=%b addr=%h required we=0 addr=%h",
                                     g, l_we[g], l_addr[g], eaddr[g]);
                        end
                        ewd[g]  = emode[g] ? (rdv(g, eaddr[g]) ^ elf[g]) : (rdv(g, eaddr[g]) + 64'd1);
                        wrph[g] = 1;
                    end else begin
                        if (l_we[g] !== 1'b1 || l_addr[g] !== eaddr[g] || l_wd[g] !== ewd[g]) begin
                            failures++;
                            $display("FAIL wr_req inst=%0d we=%b addr=%h wd=%h required we=1 addr=%h wd=%h",
                                     g, l_we[g], l_addr[g], l_wd[g], eaddr[g], ewd[g]);
                        end
                        ram[{1'(g), eaddr[g]}] = ewd[g];
                        ecnt[g]  = ecnt[g] + 1;
                        elf[g]   = nxt(elf[g]);
                        eaddr[g] = elf[g] & emask[g];
                        wrph[g]  = 0;
                        if (ecnt[g] == enum_q[g]) begin
                            erun[g] = 0; ebusy[g] = 0; edone[g] = 1;
                        end
                    end
                    if (g == 0) begin
                        log_addr.push_back(l_addr[g]);
                        log_wd.push_back(l_wd[g]);
                        log_we.push_back(l_we[g]);
                    end
                end
                if (zpend[g]) begin
                    zpend[g] = 0; ebusy[g] = 0; edone[g] = 1;
                end else if (l_start && !ebusy[g]) begin
                    if (g == 0) ram.delete();
                    emask[g] = l_mask; enum_q[g] = l_num; emode[g] = l_mode;
                    ecnt[g] = '0; edone[g] = 0; ebusy[g] = 1; wrph[g] = 0;
                    elf[g] = (l_seed == 16'd0) ? 64'd1 : {48'd0, l_seed};
                    for (int k = 0; k < g * 4; k++) elf[g] = nxt(elf[g]);
                    eaddr[g] = elf[g] & emask[g];
                    if (l_num == 32'd0) zpend[g] = 1;
                    else erun[g] = 1;
                end
            end
            if (l_rst) armed = 1'b1;

            if (armed) begin
                checks++;
                if (busy_a[g] !== ebusy[g] || done_a[g] !== edone[g] || cnt_a[g] !== ecnt[g]) begin
                    failures++;
                    $display("FAIL status inst=%0d busy=%b done=%b cnt=%0d required busy=%b done=%b cnt=%0d",
                             g, busy_a[g], done_a[g], cnt_a[g], ebusy[g], edone[g], ecnt[g]);
                end
                checks++;
                if (mem_req_a[g] !== 1'b0 && !erun[g]) begin
                    failures++;
                    $display("FAIL req_idle inst=%0d req=%b required 0", g, mem_req_a[g]);
                end
            end

            // memory responder
            if (l_req[g] && l_rdy[g]) begin
                wait_cnt[g] = 0;
                if (!l_rst && l_we[g] === 1'b0) begin
                    rd_cnt[g]  = rd_lat;
                    rd_addr[g] = l_addr[g];
                end
            end
            mem_rvalid_a[g] = 1'b0;
            if (!armed) mem_rdata_a[g] = '0;
            if (rd_cnt[g] > 0) begin
                rd_cnt[g]--;
                if (rd_cnt[g] == 0) begin
                    mem_rvalid_a[g] = 1'b1;
                    mem_rdata_a[g]  = rdv(g, rd_addr[g]);
                end
            end
            if (mem_req_a[g] === 1'b1 && wait_cnt[g] < stall_len) begin
                mem_ready_a[g] = 1'b0;
                wait_cnt[g]++;
            end else begin
                mem_ready_a[g] = 1'b1;
            end
            l_req[g]  = (mem_req_a[g] === 1'b1);
            l_rdy[g]  = mem_ready_a[g];
            l_we[g]   = mem_we_a[g];
            l_addr[g] = mem_addr_a[g];
            l_wd[g]   = mem_wdata_a[g];
        end
        l_rst = reset; l_start = start; l_seed = seed;
        l_mask = range_mask; l_num = num_updates; l_mode = mode;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    // start pulse, then scramble the inputs to prove they were latched
    task automatic run(input logic [15:0] sd, input logic [63:0] mk,
                       input logic [31:0] n, input logic md);
        seed = sd; range_mask = mk; num_updates = n; mode = md; start = 1'b1;
        tick(1);
        start = 1'b0;
        seed = 16'hBEEF; range_mask = '0; num_updates = 32'd3; mode = ~md;
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (!(done_a[0] === 1'b1 && done_a[1] === 1'b1) && k < lim) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= lim) begin
            failures++;
            $display("FAIL timeout waited=%0d cycles required done", k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        tick(3);
        chk("rst_req", mem_req_a[0], 0);
        chk("rst_busy", busy_a[0], 0);
        chk("rst_addr", mem_addr_a[0], 0);
        chk("rst_wdata", mem_wdata_a[0], 0);
        reset = 1'b0;
        tick(1);

        // two increments, zero-wait memory holding 5
        stall_len = 0; rd_lat = 1; fill = 64'd5;
        b = log_addr.size();
        run(16'd1, '1, 32'd2, 1'b0);
        wait_done(200);
        chk("t1_len", 64'(log_addr.size() - b), 4);
        chk("t1_rd0_addr", log_addr[b], 64'd1);
        chk("t1_rd0_we", log_we[b], 0);
        chk("t1_wr0_addr", log_addr[b+1], 64'd1);
        chk("t1_wr0_data", log_wd[b+1], 64'd6);
        chk("t1_rd1_addr", log_addr[b+2], 64'hD800_0000_0000_0000);
        chk("t1_wr1_data", log_wd[b+3], 64'd6);
        chk("t1_done", done_a[0], 1);
        chk("t1_cnt", cnt_a[0], 2);

        // zero seed replaced by 1
        b = log_addr.size();
        run(16'd0, 64'hFF, 32'd2, 1'b0);
        wait_done(200);
        chk("t2_addr0", log_addr[b], 64'h01);
        chk("t2_addr1", log_addr[b+2], 64'h00);

        // XOR mode
        fill = 64'hF0;
        b = log_addr.size();
        run(16'd1, '1, 32'd1, 1'b1);
        wait_done(200);
        chk("t3_xor_wd", log_wd[b+1], 64'hF1);

        // stalled handshakes, increment wrap
        stall_len = 5; fill = '1;
        b = log_addr.size();
        run(16'd1, '1, 32'd2, 1'b0);
        wait_done(400);
        chk("t4_len", 64'(log_addr.size() - b), 4);
        chk("t4_wrap0", log_wd[b+1], 64'd0);
        chk("t4_wrap1", log_wd[b+3], 64'd0);

        // zero-length run
        stall_len = 0; fill = '0;
        b = log_addr.size();
        run(16'd7, '1, 32'd0, 1'b0);
        chk("t5_busy_c1", busy_a[0], 1);
        chk("t5_done_c1", done_a[0], 0);
        tick(1);
        chk("t5_done_c2", done_a[0], 1);
        chk("t5_busy_c2", busy_a[1], 0);
        chk("t5_no_access", 64'(log_addr.size() - b), 0);

        // start while busy is ignored
        stall_len = 5;
        b = log_addr.size();
        run(16'd1, '1, 32'd1, 1'b0);
        tick(2);
        run(16'h55, 64'hF, 32'd7, 1'b1);
        wait_done(400);
        chk("t6_len", 64'(log_addr.size() - b), 2);
        chk("t6_addr", log_addr[b], 64'd1);
        chk("t6_wd", log_wd[b+1], 64'd1);
        chk("t6_cnt", cnt_a[0], 1);

        // address collisions accumulate through memory
        stall_len = 1; rd_lat = 2; fill = 64'd100;
        run(16'hACE1, 64'h7, 32'd20, 1'b0);
        wait_done(2000);
        chk("t7_cnt", cnt_a[0], 20);
        run(16'h1234, 64'h3, 32'd12, 1'b1);
        wait_done(2000);
        chk("t7_cnt_xor", cnt_a[1], 12);

        // reset in RD_WAIT, read data arrives afterwards
        stall_len = 0; rd_lat = 4; fill = '0;
        b = log_addr.size();
        run(16'd1, '1, 32'd2, 1'b0);
        begin
            int k;
            k = 0;
            while (log_addr.size() == b && k < 30) begin
                tick(1);
                k++;
            end
            chk("t8_read_seen", 64'(k < 30), 1);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(8);
        chk("t8_req", mem_req_a[0], 0);
        chk("t8_busy", busy_a[0], 0);
        chk("t8_done", done_a[0], 0);
        chk("t8_cnt", cnt_a[0], 0);
        chk("t8_no_write", 64'(log_addr.size() - b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
